mux_sel_sequencer: RTL and testbench
====================================

MUX_SEL_SEQUENCER -- requirements
Module: mux_sel_sequencer

Interface
REQ-001 Parameter MSB_FIRST, default 0; 0 = select order 0..7, 1 = select order 7..0.
REQ-002 Parameter GAP_CYCLES, default 0, range 0..15; idle cycles inserted after each word.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_data  input  8  parallel word offered upstream.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  block can accept a word this cycle (combinational).
REQ-008 hold  input  1  downstream stall request.
REQ-009 word  output  8  registered copy of the accepted word; drives the 8:1 mux data input.
REQ-010 sel  output  3  registered bit index; drives the 8:1 mux select.
REQ-011 bit_valid  output  1  word[sel] is a valid serial bit this cycle.
REQ-012 last  output  1  current valid bit is the final bit of the word.
REQ-013 busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 FSM states: IDLE, SHIFT, GAP; encoding is free.
REQ-015 START = 0 and END = 7 when MSB_FIRST=0; START = 7 and END = 0 when MSB_FIRST=1.
REQ-016 Acceptance is in_valid & in_ready at a rising edge.
REQ-017 in_ready = !rst & !hold & (state==IDLE | (state==SHIFT & sel==END & GAP_CYCLES==0)).
REQ-018 On acceptance: word <= in_data, sel <= START, state <= SHIFT.
REQ-019 In SHIFT with hold=0, sel steps toward END by 1 per cycle; exactly 8 valid bit cycles per word.
REQ-020 bit_valid = (state==SHIFT) & !hold.
REQ-021 last = bit_valid & (sel==END).
REQ-022 In SHIFT with hold=1, sel, word, state and the gap counter are frozen; no bit is consumed.
REQ-023 From SHIFT at sel==END with hold=0 and no acceptance: go to GAP if GAP_CYCLES>0, otherwise to IDLE.
REQ-024 Back-to-back (GAP_CYCLES=0): acceptance in the last cycle reloads word, sets sel to START and stays in SHIFT, giving a continuous bit stream with no bubble.
REQ-025 GAP: a 4-bit counter holds the state for exactly GAP_CYCLES unfrozen cycles, then the FSM returns to IDLE; bit_valid=0 and in_ready=0 throughout; hold freezes the counter.
REQ-026 word is held stable from acceptance until the next acceptance; it is not cleared on return to IDLE.
REQ-027 In IDLE, sel holds its last value and bit_valid=0.
REQ-028 in_valid while in_ready=0 has no effect; in_data need not be held by this block.

Reset
REQ-029 On rst asserted, asynchronously: state=IDLE, word=8'h00, sel=3'd0, gap counter=0; hence bit_valid=0, last=0, busy=0, in_ready=0.
REQ-030 Reset mid-word aborts the word with no further bit_valid; the first acceptance after rst falls resumes normal operation.
REQ-031 After rst deasserts with hold=0, in_ready=1 in the first cycle.

Verification
REQ-032 MSB_FIRST=0, GAP=0: accept 8'hA5 -> 8 cycles, sel 0..7, word[sel]=1,0,1,0,0,1,0,1, last only at sel=7, then busy=0.
REQ-033 MSB_FIRST=1: accept 8'h81 -> sel 7..0, bits 1,0,0,0,0,0,0,1, last at sel=0.
REQ-034 GAP=0, in_valid held high with 8'h3C then 8'hC3 -> 16 consecutive bit_valid cycles, last pulses at cycles 8 and 16, second acceptance at the first last.
REQ-035 hold=1 for 3 cycles while sel=4 -> sel stays 4, bit_valid=0 for 3 cycles, total word duration 11 cycles, bit order intact.
REQ-036 GAP=3: two queued words -> 3 cycles of busy=1, bit_valid=0, in_ready=0 between the words; the second word starts 12 cycles after the first.
REQ-037 rst pulse at sel=5 -> all outputs at reset values immediately, no last pulse; next accepted 8'hFF streams correctly from sel=0.

Source files
------------

// File: rtl/mux_sel_sequencer.sv
// Bit-serialiser: accepts a parallel byte and steps an 8:1 mux select across it, one bit per cycle.
// Latency: first bit is presented the cycle after acceptance; 8 bit cycles per word, then GAP_CYCLES idle cycles.
// Backpressure: hold freezes select, word, state and gap counter; in_ready drops while busy (except the final bit when GAP_CYCLES==0).
//
// Ports:
//   clk, rst              single clock, asynchronous active-high reset
//   in_data/in_valid      upstream word offer; in_ready is combinational
//   hold                  downstream stall request
//   word, sel             registered mux data and select
//   bit_valid, last       word[sel] is a valid bit / the final bit of the word
//   busy                  FSM is not idle
module mux_sel_sequencer #(
    parameter bit          MSB_FIRST  = 1'b0,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       hold,
    output logic [7:0] word,
    output logic [2:0] sel,
    output logic       bit_valid,
    output logic       last,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [2:0] START    = MSB_FIRST ? 3'd7 : 3'd0;
    localparam logic [2:0] END      = MSB_FIRST ? 3'd0 : 3'd7;
    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);
    localparam bit         NO_GAP   = (GAP_CYCLES == 0);

    state_t     state_q, state_d;
    logic [7:0] word_q,  word_d;
    logic [2:0] sel_q,   sel_d;
    logic [3:0] gap_q,   gap_d;
    logic       accept;

    // A new word may be taken in IDLE, or on the final bit when there is no gap,
    // which lets back-to-back words stream without a bubble.
    always_comb begin
        in_ready = !rst && !hold &&
                   ((state_q == IDLE) ||
                    ((state_q == SHIFT) && (sel_q == END) && NO_GAP));
    end

    assign accept    = in_valid && in_ready;
    assign bit_valid = (state_q == SHIFT) && !hold;
    assign last      = bit_valid && (sel_q == END);
    assign busy      = (state_q != IDLE);
    assign word      = word_q;
    assign sel       = sel_q;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        sel_d   = sel_q;
        gap_d   = gap_q;

        case (state_q)
            IDLE: begin
                // sel and word keep their last values while idle
            end
            SHIFT: begin
                if (!hold) begin
                    if (sel_q == END) begin
                        if (!NO_GAP) begin
                            state_d = GAP;
                            gap_d   = GAP_LOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        sel_d = MSB_FIRST ? (sel_q - 3'd1) : (sel_q + 3'd1);
                    end
                end
            end
            GAP: begin
                // Counter was loaded with GAP_CYCLES; leave on the cycle it reads 1
                // so exactly GAP_CYCLES unfrozen cycles are spent here.
                if (!hold) begin
                    if (gap_q <= 4'd1) begin
                        state_d = IDLE;
                        gap_d   = 4'd0;
                    end else begin
                        gap_d = gap_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Acceptance overrides the end-of-word transition (back-to-back reload).
        if (accept) begin
            word_d  = in_data;
            sel_d   = START;
            state_d = SHIFT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= 8'h00;
            sel_q   <= 3'd0;
            gap_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            sel_q   <= sel_d;
            gap_q   <= gap_d;
        end
    end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer: three instances (LSB-first/no gap, MSB-first/no gap, LSB-first/gap 3).
// Expected bits are queued when a word is offered; a negedge monitor pops one entry per bit_valid cycle.
// Timing properties (latency, stalls, gaps, reset) are checked directly by the stimulus thread.
module tb_mux_sel_sequencer;

    typedef struct packed {
        logic [2:0] sel;
        logic       b;
        logic       last;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] in_data   [3];
    logic       in_valid  [3];
    logic       hold      [3];
    logic       in_ready  [3];
    logic [7:0] word_o    [3];
    logic [2:0] sel_o     [3];
    logic       bit_valid [3];
    logic       last      [3];
    logic       busy      [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int n_chk  = 0;
    int n_pass = 0;

    mux_sel_sequencer #(.MSB_FIRST(1'b0), .GAP_CYCLES(0)) u_lsb (
        .clk(clk), .rst(rst),
        .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .hold(hold[0]), .word(word_o[0]), .sel(sel_o[0]),
        .bit_valid(bit_valid[0]), .last(last[0]), .busy(busy[0])
    );

    mux_sel_sequencer #(.MSB_FIRST(1'b1), .GAP_CYCLES(0)) u_msb (
        .clk(clk), .rst(rst),
        .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .hold(hold[1]), .word(word_o[1]), .sel(sel_o[1]),
        .bit_valid(bit_valid[1]), .last(last[1]), .busy(busy[1])
    );

    mux_sel_sequencer #(.MSB_FIRST(1'b0), .GAP_CYCLES(3)) u_gap (
        .clk(clk), .rst(rst),
        .in_data(in_data[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .hold(hold[2]), .word(word_o[2]), .sel(sel_o[2]),
        .bit_valid(bit_valid[2]), .last(last[2]), .busy(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Queue the expected bit sequence of a word (first n bits of it).
    task automatic push_word(input int k, input logic [7:0] w, input bit msb, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.sel  = msb ? 3'(7 - i) : 3'(i);
            e.b    = w[e.sel];
            e.last = (i == 7);
            case (k)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    task automatic pop_check(input int k);
        exp_t e;
        bit   got;
        got = 1'b0;
        e   = '0;
        case (k)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
        endcase
        if (!got) begin
            chk($sformatf("unexpected_bit_dut%0d", k), 1, 0);
        end else begin
            chk($sformatf("sel_dut%0d", k),  int'(sel_o[k]), int'(e.sel));
            chk($sformatf("bit_dut%0d", k),  int'(word_o[k][sel_o[k]]), int'(e.b));
            chk($sformatf("last_dut%0d", k), int'(last[k]), int'(e.last));
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (bit_valid[k]) pop_check(k);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cycn(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        int n;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data[k]  = 8'h00;
            in_valid[k] = 1'b0;
            hold[k]     = 1'b0;
        end
        cycn(2);

        // Reset state
        chk("rst_busy",      int'(busy[0]), 0);
        chk("rst_bit_valid", int'(bit_valid[0]), 0);
        chk("rst_last",      int'(last[0]), 0);
        chk("rst_in_ready",  int'(in_ready[0]), 0);
        chk("rst_sel",       int'(sel_o[0]), 0);
        chk("rst_word",      int'(word_o[0]), 0);

        rst = 1'b0;
        #1;
        chk("ready_after_rst", int'(in_ready[0]), 1);

        // LSB-first 8'hA5
        in_data[0] = 8'hA5; in_valid[0] = 1'b1;
        push_word(0, 8'hA5, 1'b0, 8);
        cyc();
        in_valid[0] = 1'b0;
        chk("a5_busy_start", int'(busy[0]), 1);
        chk("a5_ready_mid",  int'(in_ready[0]), 0);
        cycn(8);
        chk("a5_busy_end",   int'(busy[0]), 0);
        chk("a5_word_kept",  int'(word_o[0]), 8'hA5);
        chk("a5_sel_kept",   int'(sel_o[0]), 7);
        chk("a5_q_empty",    q0.size(), 0);

        // MSB-first 8'h81
        in_data[1] = 8'h81; in_valid[1] = 1'b1;
        push_word(1, 8'h81, 1'b1, 8);
        cyc();
        in_valid[1] = 1'b0;
        chk("81_sel_start", int'(sel_o[1]), 7);
        cycn(8);
        chk("81_busy_end", int'(busy[1]), 0);
        chk("81_q_empty",  q1.size(), 0);

        // Back-to-back 8'h3C then 8'hC3 with in_valid held high
        in_data[0] = 8'h3C; in_valid[0] = 1'b1;
        push_word(0, 8'h3C, 1'b0, 8);
        cyc();
        in_data[0] = 8'hC3;
        push_word(0, 8'hC3, 1'b0, 8);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("b2b_valid_%0d", i), int'(bit_valid[0]), 1);
            if (i == 7 || i == 15) chk($sformatf("b2b_last_%0d", i), int'(last[0]), 1);
            if (i == 6) chk("b2b_ready_before_last", int'(in_ready[0]), 0);
            if (i == 7) chk("b2b_ready_at_last", int'(in_ready[0]), 1);
            cyc();
            if (i == 7) in_valid[0] = 1'b0;
        end
        chk("b2b_busy_end", int'(busy[0]), 0);

        // Hold for 3 cycles at sel=4
        in_data[0] = 8'h5A; in_valid[0] = 1'b1;
        push_word(0, 8'h5A, 1'b0, 8);
        cyc();
        in_valid[0] = 1'b0;
        cycn(4);
        hold[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("hold_sel_%0d", i),   int'(sel_o[0]), 4);
            chk($sformatf("hold_valid_%0d", i), int'(bit_valid[0]), 0);
            chk($sformatf("hold_busy_%0d", i),  int'(busy[0]), 1);
            cyc();
        end
        hold[0] = 1'b0;
        cycn(3);
        chk("hold_busy_at_10", int'(busy[0]), 1);
        cyc();
        chk("hold_busy_at_11", int'(busy[0]), 0);
        chk("hold_q_empty",    q0.size(), 0);

        // GAP_CYCLES=3 with two queued words
        in_data[2] = 8'h96; in_valid[2] = 1'b1;
        push_word(2, 8'h96, 1'b0, 8);
        cyc();
        in_data[2] = 8'h69;
        push_word(2, 8'h69, 1'b0, 8);
        n = 0;
        while (!in_ready[2] && n < 50) begin
            if (n >= 8 && n <= 10) begin
                chk($sformatf("gap_busy_%0d", n),  int'(busy[2]), 1);
                chk($sformatf("gap_valid_%0d", n), int'(bit_valid[2]), 0);
            end
            cyc();
            n++;
        end
        cyc();
        n++;
        in_valid[2] = 1'b0;
        chk("gap_second_start", n, 12);
        chk("gap_second_sel0",  int'(sel_o[2]), 0);
        cycn(8);
        chk("gap_tail_busy",  int'(busy[2]), 1);
        chk("gap_tail_ready", int'(in_ready[2]), 0);
        cycn(3);
        chk("gap_end_busy",   int'(busy[2]), 0);
        chk("gap_q_empty",    q2.size(), 0);

        // Reset pulse at sel=5, then 8'hFF
        in_data[0] = 8'h33; in_valid[0] = 1'b1;
        push_word(0, 8'h33, 1'b0, 5);
        cyc();
        in_valid[0] = 1'b0;
        cycn(5);
        chk("pre_rst_sel", int'(sel_o[0]), 5);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", int'(bit_valid[0]), 0);
        chk("mid_rst_last",  int'(last[0]), 0);
        chk("mid_rst_busy",  int'(busy[0]), 0);
        chk("mid_rst_sel",   int'(sel_o[0]), 0);
        chk("mid_rst_word",  int'(word_o[0]), 0);
        chk("mid_rst_ready", int'(in_ready[0]), 0);
        cyc();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", int'(in_ready[0]), 1);
        in_data[0] = 8'hFF; in_valid[0] = 1'b1;
        push_word(0, 8'hFF, 1'b0, 8);
        cyc();
        in_valid[0] = 1'b0;
        chk("ff_sel_start", int'(sel_o[0]), 0);
        cycn(8);
        chk("ff_busy_end", int'(busy[0]), 0);

        cycn(2);
        chk("final_q0_empty", q0.size(), 0);
        chk("final_q1_empty", q1.size(), 0);
        chk("final_q2_empty", q2.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
